// File: rtl/reg_file_pkg.sv
// Shared defaults and FSM state type for the write-back register file.
package reg_file_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

endpackage

// File: rtl/reg_file_if.sv
// Write, read and clear signals between write-back/decode and the register file.
interface reg_file_if #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd0_addr;
  logic [ADDR_W-1:0] rd1_addr;
  logic [DATA_W-1:0] rd0_data;
  logic [DATA_W-1:0] rd1_data;
  logic              clr_req;
  logic              busy;

  modport master (
    output wr_valid, wr_addr, wr_data, rd0_addr, rd1_addr, clr_req,
    input  wr_ready, rd0_data, rd1_data, busy
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd0_addr, rd1_addr, clr_req,
    output wr_ready, rd0_data, rd1_data, busy
  );

endinterface

// File: rtl/rf_register.sv
// One register built from independent per-bit storage cells with async clear.
module rf_register #(
  parameter int DATA_W = reg_file_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  for (genvar b = 0; b < DATA_W; b++) begin : g_cell
    logic bit_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bit_q <= 1'b0;
      end else if (we_i) begin
        bit_q <= d_i[b];
      end
    end

    assign q_o[b] = bit_q;
  end

endmodule

// File: rtl/reg_file_wb.sv
// Write-back register file: two bypassed read ports, one handshaked write
// port and a sequencer that zeroes one register per cycle on request.
module reg_file_wb #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  reg_file_if.slave bus
);

  import reg_file_pkg::*;

  localparam int N_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_REGS - 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              wr_ready;
  logic              wr_acc;
  logic              clr_we;
  logic [N_REGS-1:0] reg_we;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_val [N_REGS];

  assign wr_ready = (state_q == IDLE);
  assign clr_we   = (state_q == CLEAR);
  assign wr_acc   = bus.wr_valid && wr_ready;

  assign bus.wr_ready = wr_ready;
  assign bus.busy     = clr_we;

  // External writes and clear writes are mutually exclusive by state.
  assign reg_wdata = clr_we ? '0 : bus.wr_data;

  for (genvar i = 0; i < N_REGS; i++) begin : g_reg
    assign reg_we[i] = (wr_acc && (bus.wr_addr == ADDR_W'(i))) ||
                       (clr_we && (cnt_q == ADDR_W'(i)));

    rf_register #(.DATA_W(DATA_W)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (reg_we[i]),
      .d_i   (reg_wdata),
      .q_o   (reg_val[i])
    );
  end

  always_comb begin
    bus.rd0_data = reg_val[bus.rd0_addr];
    bus.rd1_data = reg_val[bus.rd1_addr];
    if (BYPASS && wr_acc && (bus.wr_addr == bus.rd0_addr)) begin
      bus.rd0_data = bus.wr_data;
    end
    if (BYPASS && wr_acc && (bus.wr_addr == bus.rd1_addr)) begin
      bus.rd1_data = bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // Terminal register detected by compare so cnt never relies on wrap.
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
